alu_rot_wb: RTL and testbench



---
 rtl/alu_rot_wb_pkg.sv | 27 ++
 rtl/alu_flag_gen.sv | 19 +
 rtl/alu_rot_wb.sv | 180 ++++++++++++++++++
 tb/tb_alu_rot_wb.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rot_wb_pkg.sv
// Shared definitions for the rotate write-back stage: op codes, FSM states,
// flag bit positions and the reset value of active-low byte registers.
package alu_rot_wb_pkg;

    localparam logic [1:0] OP_RL  = 2'd0;
    localparam logic [1:0] OP_RR  = 2'd1;
    localparam logic [1:0] OP_RLD = 2'd2;
    localparam logic [1:0] OP_RRD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_WR_A = 2'd2
    } state_t;

    localparam int FLAG_S = 7;
    localparam int FLAG_Z = 6;
    localparam int FLAG_Y = 5;
    localparam int FLAG_H = 4;
    localparam int FLAG_X = 3;
    localparam int FLAG_P = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 0;

    localparam logic [7:0] NOT_RESET_VAL = 8'hFF;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational S/Z/Y/X/P flag generator on an active-high ALU result byte.
// Shared by the ALU write-back stages.
module alu_flag_gen (
    input  logic [7:0] i_result,
    output logic       o_s,
    output logic       o_z,
    output logic       o_y,
    output logic       o_x,
    output logic       o_p
);

    assign o_s = i_result[7];
    assign o_z = (i_result == 8'h00);
    assign o_y = i_result[5];
    assign o_x = i_result[3];
    // Z80 P/V is set for even parity, hence the inverted reduction XOR.
    assign o_p = ~^i_result;

endmodule

// File: rtl/alu_rot_wb.sv
// Rotate write-back stage: captures RL/RR/RLD/RRD results, owns the flag
// register and commits A (and (HL) for RLD/RRD). Optional memory-ack
// timeout is compiled in with ALU_ROT_WB_TIMEOUT_EN.
module alu_rot_wb
    import alu_rot_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        notReset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [7:0]  notRL,
    input  logic [7:0]  notRR,
    input  logic [15:0] notRLD,
    input  logic [15:0] notRRD,
    output logic        ready,
    output logic        done,
    output logic        regWe,
    output logic [7:0]  notRegData,
    output logic        memReq,
    input  logic        memAck,
    output logic [7:0]  notMemData,
    output logic [7:0]  notF,
    output logic        notFlag_C,
    output logic        error
);

    state_t     r_state, w_next_state;
    logic [7:0] r_not_acc, r_not_mem, r_not_f, r_not_f_pend;
    logic [7:0] w_not_acc_sel, w_not_mem_sel, w_flags;
    logic       w_carry, w_capture, w_timeout;
    logic       w_s, w_z, w_y, w_x, w_p;

    assign w_capture = (r_state == ST_IDLE) && start;

    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        w_not_acc_sel = notRL;
        w_not_mem_sel = NOT_RESET_VAL;
        w_carry       = ~r_not_f[FLAG_C];
        case (op)
            OP_RL: begin
                w_not_acc_sel = notRL;
                w_carry       = ~notRR[6];
            end
            OP_RR: begin
                w_not_acc_sel = notRR;
                w_carry       = ~notRL[1];
            end
            OP_RLD: begin
                w_not_acc_sel = notRLD[7:0];
                w_not_mem_sel = notRLD[15:8];
            end
            default: begin
                w_not_acc_sel = notRRD[7:0];
                w_not_mem_sel = notRRD[15:8];
            end
        endcase
    end

    alu_flag_gen u_flag_gen (
        .i_result (~w_not_acc_sel),
        .o_s      (w_s),
        .o_z      (w_z),
        .o_y      (w_y),
        .o_x      (w_x),
        .o_p      (w_p)
    );

    always_comb begin
        w_flags         = 8'h00;
        w_flags[FLAG_S] = w_s;
        w_flags[FLAG_Z] = w_z;
        w_flags[FLAG_Y] = w_y;
        w_flags[FLAG_X] = w_x;
        w_flags[FLAG_P] = w_p;
        w_flags[FLAG_C] = w_carry;
    end

`ifdef ALU_ROT_WB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_error;

    assign w_timeout = (r_state == ST_MEM) && !memAck &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign error     = r_error;

    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            r_cnt   <= '0;
            r_error <= 1'b0;
        end else begin
            if (w_capture) begin
                r_cnt   <= '0;
                r_error <= 1'b0;
            end else if (r_state == ST_MEM) begin
                r_cnt   <= r_cnt + CNT_W'(1);
            end
            if (w_timeout)
                r_error <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign error     = 1'b0;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cfg
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start)
                    w_next_state = (op == OP_RL || op == OP_RR) ? ST_WR_A : ST_MEM;
            end
            ST_MEM: begin
                if (memAck)
                    w_next_state = ST_WR_A;
                else if (w_timeout)
                    w_next_state = ST_IDLE;
            end
            ST_WR_A: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ready  = 1'b0;
        memReq = 1'b0;
        regWe  = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_IDLE: ready  = 1'b1;
            ST_MEM:  memReq = 1'b1;
            ST_WR_A: begin
                regWe = 1'b1;
                done  = 1'b1;
            end
            default: ready = 1'b0;
        endcase
    end

    // NOTE: holding registers are reset as well, so a reset mid-op leaves no
    // partial result on notRegData/notMemData.
    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            r_not_acc    <= NOT_RESET_VAL;
            r_not_mem    <= NOT_RESET_VAL;
            r_not_f_pend <= NOT_RESET_VAL;
            r_not_f      <= NOT_RESET_VAL;
        end else begin
            if (w_capture) begin
                r_not_acc    <= w_not_acc_sel;
                r_not_mem    <= w_not_mem_sel;
                r_not_f_pend <= ~w_flags;
            end
            if (r_state == ST_WR_A)
                r_not_f <= r_not_f_pend;
        end
    end

    assign notRegData = r_not_acc;
    assign notMemData = r_not_mem;
    assign notF       = r_not_f;
    assign notFlag_C  = r_not_f[FLAG_C];

endmodule

// File: tb/tb_alu_rot_wb.sv
// Directed bench for alu_rot_wb: scoreboard of expected commits, sampled on
// the falling clock edge. Covers the timeout build when ALU_ROT_WB_TIMEOUT_EN is set.
module tb_alu_rot_wb;
    import alu_rot_wb_pkg::*;

    logic        clk = 1'b0;
    logic        notReset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [7:0]  notRL = 8'hFF, notRR = 8'hFF;
    logic [15:0] notRLD = 16'hFFFF, notRRD = 16'hFFFF;
    logic        memAck = 1'b0;
    logic        ready, done, regWe, memReq, notFlag_C, error;
    logic [7:0]  notRegData, notMemData, notF;

    always #5 clk = ~clk;

    alu_rot_wb #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .notReset   (notReset),
        .start      (start),
        .op         (op),
        .notRL      (notRL),
        .notRR      (notRR),
        .notRLD     (notRLD),
        .notRRD     (notRRD),
        .ready      (ready),
        .done       (done),
        .regWe      (regWe),
        .notRegData (notRegData),
        .memReq     (memReq),
        .memAck     (memAck),
        .notMemData (notMemData),
        .notF       (notF),
        .notFlag_C  (notFlag_C),
        .error      (error)
    );

    typedef struct {
        logic [7:0] acc;
        logic [7:0] mem;
        logic [7:0] f;
        int         req;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    logic [7:0] cur_f = 8'hFF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Reference flags (active-low) for an active-high result and carry.
    function automatic logic [7:0] model_not_f(input logic [7:0] r, input logic c);
        logic [7:0] f;
        int ones;
        f = 8'h00;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(r[i]);
        f[7] = r[7];
        f[6] = (r == 8'h00);
        f[5] = r[5];
        f[3] = r[3];
        f[2] = (ones % 2 == 0);
        f[0] = c;
        return ~f;
    endfunction

    // Called right after a falling edge; returns at the falling edge after capture.
    task automatic issue(input logic [1:0] o, input logic [7:0] rl, input logic [7:0] rr,
                         input logic [15:0] rld, input logic [15:0] rrd);
        check("ready_before_start", 32'(ready), 32'd1);
        op     = o;
        notRL  = rl;
        notRR  = rr;
        notRLD = rld;
        notRRD = rrd;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Follows one op to its commit and checks it against the scoreboard head.
    task automatic run(input string tag, input int ack_delay, input bit poke);
        exp_t e;
        int n = 0;
        int req_idx = -1;
        int done_idx = -1;
        e = sb.pop_front();
        for (int cyc = 0; cyc < 64 && done_idx < 0; cyc++) begin
            check({tag, "_busy"}, 32'(ready), 32'd0);
            if (memReq) begin
                n++;
                if (req_idx < 0) req_idx = cyc;
                check({tag, "_memdata"}, 32'(notMemData), 32'(e.mem));
            end
            if (poke) begin
                start = memReq && (n == 1);
                op    = OP_RL;
            end
            memAck = (ack_delay == 0) ? 1'b1 : (memReq && n > ack_delay);
            if (done) begin
                done_idx = cyc;
                check({tag, "_regwe"}, 32'(regWe), 32'd1);
                check({tag, "_regdata"}, 32'(notRegData), 32'(e.acc));
                check({tag, "_f_not_yet"}, 32'(notF), 32'(cur_f));
            end else begin
                check({tag, "_no_early_we"}, 32'(regWe), 32'd0);
            end
            @(negedge clk);
        end
        start  = 1'b0;
        memAck = 1'b0;
        check({tag, "_done_seen"}, 32'(done_idx >= 0), 32'd1);
        check({tag, "_req_cycles"}, 32'(n), 32'(e.req));
        if (e.req > 0)
            check({tag, "_done_after_req"}, 32'(done_idx - req_idx), 32'(e.req));
        cur_f = e.f;
        check({tag, "_notf"}, 32'(notF), 32'(cur_f));
        check({tag, "_notflag_c"}, 32'(notFlag_C), 32'(cur_f[0]));
        check({tag, "_ready_after"}, 32'(ready), 32'd1);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_regwe"}, 32'(regWe), 32'd0);
        check({tag, "_memreq"}, 32'(memReq), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_regdata"}, 32'(notRegData), 32'hFF);
        check({tag, "_memdata"}, 32'(notMemData), 32'hFF);
        check({tag, "_notf"}, 32'(notF), 32'hFF);
        check({tag, "_notflag_c"}, 32'(notFlag_C), 32'd1);
    endtask

    initial begin
        logic [7:0] a_rl, a_rr, a_res;
        logic       c;
        int         n;

        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        notReset = 1'b1;
        @(negedge clk);

        // RL: A = 0x02, C from old bit 7 (bit 6 of RR result) = 1.
        sb.push_back('{acc: 8'hFD, mem: 8'hFF, f: 8'hFE, req: 0});
        issue(OP_RL, ~8'h02, ~8'h40, 16'hFFFF, 16'hFFFF);
        run("rl", 0, 1'b0);

        // RR: A = 0x00 -> Z, P set; C from old bit 0 = 1.
        sb.push_back('{acc: 8'hFF, mem: 8'hFF, f: 8'hBA, req: 0});
        issue(OP_RR, ~8'h02, ~8'h00, 16'hFFFF, 16'hFFFF);
        run("rr", 0, 1'b0);

        // RLD: A = 0x13, (HL) = 0x42, ack after 3 wait cycles, C preserved.
        sb.push_back('{acc: 8'hEC, mem: 8'hBD, f: 8'hFE, req: 4});
        issue(OP_RLD, 8'hFF, 8'hFF, ~16'h4213, 16'hFFFF);
        run("rld", 3, 1'b0);

        // RRD: zero-wait ack already high at capture, stray start mid-op.
        sb.push_back('{acc: 8'h7F, mem: 8'hA5, f: 8'h7E, req: 1});
        memAck = 1'b1;
        issue(OP_RRD, 8'hFF, 8'hFF, 16'hFFFF, ~16'h5A80);
        run("rrd", 0, 1'b1);
        check("rrd_stray_start_done", 32'(done), 32'd0);
        check("rrd_stray_start_ready", 32'(ready), 32'd1);
        @(negedge clk);
        check("rrd_stray_start_regwe", 32'(regWe), 32'd0);
        check("rrd_stray_start_regdata", 32'(notRegData), 32'h7F);

        // Random RL/RR and one random RLD against the flag model.
        for (int k = 0; k < 5; k++) begin
            a_rl = 8'($urandom);
            a_rr = 8'($urandom);
            if (k == 4) begin
                c = ~cur_f[0];
                sb.push_back('{acc: ~a_rl, mem: ~a_rr, f: model_not_f(a_rl, c), req: 2});
                issue(OP_RLD, 8'hFF, 8'hFF, ~{a_rr, a_rl}, 16'hFFFF);
                run("rnd_rld", 1, 1'b0);
            end else begin
                a_res = (k % 2 == 0) ? a_rl : a_rr;
                c     = (k % 2 == 0) ? a_rr[6] : a_rl[1];
                sb.push_back('{acc: ~a_res, mem: 8'hFF, f: model_not_f(a_res, c), req: 0});
                issue((k % 2 == 0) ? OP_RL : OP_RR, ~a_rl, ~a_rr, 16'hFFFF, 16'hFFFF);
                run("rnd_rot", 2, 1'b0);
            end
        end

`ifdef ALU_ROT_WB_TIMEOUT_EN
        // RLD with no ack: abandon after 16 MEM cycles, error set, no commit.
        issue(OP_RLD, 8'hFF, 8'hFF, ~16'h1234, 16'hFFFF);
        n = 0;
        for (int cyc = 0; cyc < 40 && (n == 0 || memReq); cyc++) begin
            if (memReq) n++;
            check("to_no_regwe", 32'(regWe), 32'd0);
            @(negedge clk);
        end
        check("to_req_cycles", 32'(n), 32'd16);
        check("to_error", 32'(error), 32'd1);
        check("to_notf_kept", 32'(notF), 32'(cur_f));
        check("to_ready", 32'(ready), 32'd1);
        // Next accepted start clears error.
        sb.push_back('{acc: 8'hF7, mem: 8'hFF, f: model_not_f(8'h08, 1'b0), req: 0});
        issue(OP_RL, ~8'h08, ~8'h00, 16'hFFFF, 16'hFFFF);
        check("to_error_cleared", 32'(error), 32'd0);
        run("to_next_rl", 0, 1'b0);
        issue(OP_RLD, 8'hFF, 8'hFF, ~16'h1234, 16'hFFFF);
        repeat (3) @(negedge clk);
`else
        // Without the timeout, MEM waits for the ack indefinitely.
        issue(OP_RLD, 8'hFF, 8'hFF, ~16'h1234, 16'hFFFF);
        n = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (memReq) n++;
            @(negedge clk);
        end
        check("noto_req_held", 32'(n), 32'd20);
        check("noto_error", 32'(error), 32'd0);
`endif

        // Asynchronous reset while waiting in MEM.
        check("rst_mem_before", 32'(memReq), 32'd1);
        #2 notReset = 1'b0;
        #1;
        check_reset_outputs("rst_mem");
        @(negedge clk);
        notReset = 1'b1;
        cur_f = 8'hFF;
        @(negedge clk);

        // RL after reset: A = 0x80 (S set, odd parity), C = 0.
        sb.push_back('{acc: 8'h7F, mem: 8'hFF, f: 8'h7F, req: 0});
        issue(OP_RL, ~8'h80, ~8'h00, 16'hFFFF, 16'hFFFF);
        run("post_rst_rl", 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
